// File: rtl/local_if.sv
// ----------------------------------------------------------------------------
// local_if
// Local RAM-style register access bus between the AXI4-Lite slave front end
// and a register bank.
//   local_waddr      master -> slave  write word address
//   local_wen        master -> slave  write strobe, one cycle per write
//   local_wdata      master -> slave  write data
//   local_raddr      master -> slave  read word address, valid with local_ren
//   local_ren        master -> slave  read strobe, one cycle per read
//   local_rdata      slave  -> master read data, valid with local_rdatavalid
//   local_rdatavalid slave  -> master one-cycle pulse, 1 cycle after local_ren
// ----------------------------------------------------------------------------
interface local_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] local_waddr;
    logic                  local_wen;
    logic [DATA_WIDTH-1:0] local_wdata;
    logic [ADDR_WIDTH-1:0] local_raddr;
    logic                  local_ren;
    logic [DATA_WIDTH-1:0] local_rdata;
    logic                  local_rdatavalid;

    modport master (
        output local_waddr, local_wen, local_wdata, local_raddr, local_ren,
        input  local_rdata, local_rdatavalid
    );

    modport slave (
        input  local_waddr, local_wen, local_wdata, local_raddr, local_ren,
        output local_rdata, local_rdatavalid
    );
endinterface : local_if

// File: rtl/local_reg_bank_cnt.sv
// ----------------------------------------------------------------------------
// local_reg_bank_cnt
// Register bank terminating the local RAM-style bus. Holds NUM_CTRL RW control
// registers (word addresses 0..NUM_CTRL-1), a read-only ID word at ID_ADDR and
// NUM_CNT saturating clear-on-read event counters at CNT_BASE..CNT_BASE+NUM_CNT-1.
// Reads have a fixed 1-cycle latency and no backpressure.
//   clk            single clock
//   rst            synchronous, active-high reset
//   local_bus      local_if slave: write/read strobes in, read data out
//   ctrl_out       control registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ctrl_wr_pulse  bit i pulses for one cycle after a write to register i
//   cnt_event      bit i increments counter i in that cycle
// ----------------------------------------------------------------------------
module local_reg_bank_cnt #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    REG_ADDR_BIT = 8,
    parameter int                    NUM_CTRL     = 4,
    parameter int                    ID_ADDR      = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'h5453_0001,
    parameter int                    CNT_BASE     = 16,
    parameter int                    NUM_CNT      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    local_if.slave                         local_bus,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
    input  logic [NUM_CNT-1:0]             cnt_event
);

    logic [DATA_WIDTH-1:0] r_ctrl [NUM_CTRL];
    logic [DATA_WIDTH-1:0] r_cnt  [NUM_CNT];
    logic [NUM_CTRL-1:0]   r_wr_pulse;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdatavalid;

    logic [NUM_CTRL-1:0]   w_ctrl_we;
    logic [NUM_CNT-1:0]    w_cnt_clr;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_ctrl_we = '0;
        w_cnt_clr = '0;
        w_rd_data = '0;

        for (int i = 0; i < NUM_CTRL; i++) begin
            if (local_bus.local_wen && local_bus.local_waddr == REG_ADDR_BIT'(i))
                w_ctrl_we[i] = 1'b1;
            if (local_bus.local_raddr == REG_ADDR_BIT'(i))
                w_rd_data = r_ctrl[i];
        end

        if (local_bus.local_raddr == REG_ADDR_BIT'(ID_ADDR))
            w_rd_data = ID_VALUE;

        for (int i = 0; i < NUM_CNT; i++) begin
            if (local_bus.local_raddr == REG_ADDR_BIT'(CNT_BASE + i)) begin
                w_rd_data    = r_cnt[i];
                w_cnt_clr[i] = local_bus.local_ren;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers and write pulses
    // ------------------------------------------------------------------
    // NOTE: these are a handful of flops rather than a RAM macro, so every
    // entry is cleared by reset; a true memory array would be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= '0;
            r_wr_pulse <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state; a same-cycle read of this address sees the old value.
            for (int i = 0; i < NUM_CTRL; i++)
                if (w_ctrl_we[i]) r_ctrl[i] <= local_bus.local_wdata;
            r_wr_pulse <= w_ctrl_we;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters with clear-on-read. A clear that coincides
    // with an event restarts the counter at 1 so that event is not lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_cnt_clr[i])
                    r_cnt[i] <= cnt_event[i] ? DATA_WIDTH'(1) : '0;
                else if (cnt_event[i] && !(&r_cnt[i]))
                    r_cnt[i] <= r_cnt[i] + DATA_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: one cycle latency, data held until the next read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata      <= '0;
            r_rdatavalid <= 1'b0;
        end else begin
            r_rdatavalid <= local_bus.local_ren;
            if (local_bus.local_ren) r_rdata <= w_rd_data;
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
    end

    assign ctrl_wr_pulse              = r_wr_pulse;
    assign local_bus.local_rdata      = r_rdata;
    assign local_bus.local_rdatavalid = r_rdatavalid;

endmodule : local_reg_bank_cnt

// File: tb/tb_local_reg_bank_cnt.sv
// ----------------------------------------------------------------------------
// tb_local_reg_bank_cnt
// Directed bench for local_reg_bank_cnt. Read expectations are queued when a
// read is issued; a monitor on the falling edge pops and compares whenever
// the DUT presents rdatavalid. A second, 8-bit instance exercises counter
// saturation in a practical number of cycles.
// ----------------------------------------------------------------------------
module tb_local_reg_bank_cnt;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NC = 4;
    localparam int NN = 4;
    localparam logic [DW-1:0] ID = 32'h5453_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    local_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    local_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(AW)) bus_s ();

    logic [NC*DW-1:0] ctrl_out;
    logic [NC-1:0]    ctrl_wr_pulse;
    logic [NN-1:0]    cnt_event;
    logic [NC*8-1:0]  ctrl_out_s;
    logic [NC-1:0]    ctrl_wr_pulse_s;
    logic [NN-1:0]    cnt_event_s;

    local_reg_bank_cnt dut (
        .clk           (clk),
        .rst           (rst),
        .local_bus     (bus),
        .ctrl_out      (ctrl_out),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .cnt_event     (cnt_event)
    );

    local_reg_bank_cnt #(.DATA_WIDTH(8), .ID_VALUE(8'h01)) dut_s (
        .clk           (clk),
        .rst           (rst),
        .local_bus     (bus_s),
        .ctrl_out      (ctrl_out_s),
        .ctrl_wr_pulse (ctrl_wr_pulse_s),
        .cnt_event     (cnt_event_s)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q [$];
    logic          exp_v = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference for rdatavalid timing: a read accepted at an edge outside
    // reset must be answered in the following cycle.
    always @(posedge clk) exp_v <= bus.local_ren && !rst;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (exp_v || bus.local_rdatavalid)
            check("rdatavalid", 128'(bus.local_rdatavalid), 128'(exp_v));
        if (bus.local_rdatavalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rdata: got %0h, expected no response", bus.local_rdata);
            end else begin
                check("rdata", 128'(bus.local_rdata), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int addr, input logic [DW-1:0] exp);
        bus.local_ren   = 1'b1;
        bus.local_raddr = AW'(addr);
        exp_q.push_back(exp);
        tick();
        bus.local_ren   = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        bus.local_wen   = 1'b1;
        bus.local_waddr = AW'(addr);
        bus.local_wdata = data;
        tick();
        bus.local_wen   = 1'b0;
    endtask

    task automatic rdwr(input int raddr, input logic [DW-1:0] exp,
                        input int waddr, input logic [DW-1:0] data);
        bus.local_wen   = 1'b1;
        bus.local_waddr = AW'(waddr);
        bus.local_wdata = data;
        bus.local_ren   = 1'b1;
        bus.local_raddr = AW'(raddr);
        exp_q.push_back(exp);
        tick();
        bus.local_wen   = 1'b0;
        bus.local_ren   = 1'b0;
    endtask

    // Read on the 8-bit instance, checked inline one cycle later.
    task automatic rd_s(input string name, input int addr, input logic [7:0] exp);
        bus_s.local_ren   = 1'b1;
        bus_s.local_raddr = AW'(addr);
        tick();
        bus_s.local_ren   = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 128'(bus_s.local_rdatavalid), 128'(1));
        check(name, 128'(bus_s.local_rdata), 128'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NC*DW-1:0] saved;
        int ign_addr [4] = '{8, 5, 18, 200};

        rst = 1'b1;
        bus.local_wen = 1'b0;   bus.local_ren = 1'b0;
        bus.local_waddr = '0;   bus.local_raddr = '0;   bus.local_wdata = '0;
        bus_s.local_wen = 1'b0; bus_s.local_ren = 1'b0;
        bus_s.local_waddr = '0; bus_s.local_raddr = '0; bus_s.local_wdata = '0;
        cnt_event = '0;
        cnt_event_s = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ctrl_out",   128'(ctrl_out),              128'(0));
        check("rst_wr_pulse",   128'(ctrl_wr_pulse),         128'(0));
        check("rst_rdata",      128'(bus.local_rdata),       128'(0));
        check("rst_rdatavalid", 128'(bus.local_rdatavalid),  128'(0));
        rst = 1'b0;
        tick();

        // Decode after reset, back-to-back reads, unmapped addresses
        rd(0, 32'h0);
        rd(8, ID);
        rd(16, 32'h0);
        rd(5, 32'h0);
        rd(20, 32'h0);
        rd(200, 32'h0);
        tick();

        // Control write with pulse
        wr(2, 32'hA5A5_0003);
        check("ctrl2_after_wr", 128'(ctrl_out[95:64]), 128'(32'hA5A5_0003));
        check("ctrl0_untouched", 128'(ctrl_out[31:0]), 128'(0));
        check("pulse_wr2",      128'(ctrl_wr_pulse),  128'(4'b0100));
        tick();
        check("pulse_wr2_end",  128'(ctrl_wr_pulse),  128'(0));
        rd(2, 32'hA5A5_0003);
        wr(3, 32'hDEAD_BEEF);
        check("ctrl3_after_wr", 128'(ctrl_out[127:96]), 128'(32'hDEAD_BEEF));
        check("pulse_wr3",      128'(ctrl_wr_pulse),    128'(4'b1000));
        tick();

        // Counter 1: five events, read, immediate re-read after clear
        cnt_event = 4'b0010;
        repeat (5) tick();
        cnt_event = '0;
        rd(17, 32'd5);
        rd(17, 32'd0);
        tick();

        // Counter 0: seven events, then read coinciding with an event
        cnt_event = 4'b0001;
        repeat (7) tick();
        rd(16, 32'd7);
        cnt_event = '0;
        rd(16, 32'd1);
        tick();

        // Same-cycle write and read of one control address
        rdwr(2, 32'hA5A5_0003, 2, 32'h1111_1111);
        check("pulse_rdwr2", 128'(ctrl_wr_pulse), 128'(4'b0100));
        rd(2, 32'h1111_1111);
        // Same-cycle write and read of different addresses
        rdwr(8, ID, 1, 32'h0000_5A5A);
        check("ctrl1_after_rdwr", 128'(ctrl_out[63:32]), 128'(32'h0000_5A5A));
        check("pulse_rdwr1",      128'(ctrl_wr_pulse),   128'(4'b0010));
        tick();

        // Writes to ID, unmapped and counter addresses are ignored
        cnt_event = 4'b0100;
        repeat (3) tick();
        cnt_event = '0;
        saved = ctrl_out;
        foreach (ign_addr[k]) begin
            wr(ign_addr[k], 32'h0000_1234);
            check($sformatf("ign_wr%0d_ctrl", ign_addr[k]),  128'(ctrl_out),      128'(saved));
            check($sformatf("ign_wr%0d_pulse", ign_addr[k]), 128'(ctrl_wr_pulse), 128'(0));
        end
        rd(8, ID);
        rd(5, 32'h0);
        rd(18, 32'd3);
        rd(3, 32'hDEAD_BEEF);
        tick();

        // Reset while a read is in flight; an event in the reset cycle is dropped
        bus.local_ren   = 1'b1;
        bus.local_raddr = AW'(2);
        cnt_event       = 4'b0100;
        rst             = 1'b1;
        tick();
        bus.local_ren = 1'b0;
        cnt_event     = '0;
        rst           = 1'b0;
        @(negedge clk);
        check("rst_midread_valid", 128'(bus.local_rdatavalid), 128'(0));
        check("rst_midread_ctrl",  128'(ctrl_out),             128'(0));
        check("rst_midread_pulse", 128'(ctrl_wr_pulse),        128'(0));
        tick();
        rd(18, 32'h0);
        rd(2, 32'h0);
        tick();

        // Saturation on the 8-bit instance: counters 2 and 3 climb to 0xFE,
        // counter 3 then sees three more events and must hold at 0xFF.
        cnt_event_s = 4'b1100;
        repeat (254) tick();
        cnt_event_s = 4'b1000;
        rd_s("sat_c2_fe", 18, 8'hFE);
        repeat (2) tick();
        cnt_event_s = '0;
        rd_s("sat_c3_ff", 19, 8'hFF);
        rd_s("sat_c2_clr", 18, 8'h00);
        rd_s("small_id", 8, 8'h01);

        repeat (3) tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_local_reg_bank_cnt
